// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with iterative shift-add multiplier and restoring divider
// behind a START/BUSY/DONE handshake.
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [OPRN_WIDTH-1:0] OPRN,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [DATA_WIDTH-1:0] HI,
    output logic                  ZERO,
    output logic                  DZ,
    output logic                  ERR
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD  = OPRN_WIDTH'(8'h01);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB  = OPRN_WIDTH'(8'h02);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL  = OPRN_WIDTH'(8'h03);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL  = OPRN_WIDTH'(8'h04);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL  = OPRN_WIDTH'(8'h05);
    localparam logic [OPRN_WIDTH-1:0] OP_AND  = OPRN_WIDTH'(8'h06);
    localparam logic [OPRN_WIDTH-1:0] OP_OR   = OPRN_WIDTH'(8'h07);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR  = OPRN_WIDTH'(8'h08);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT  = OPRN_WIDTH'(8'h09);
    localparam logic [OPRN_WIDTH-1:0] OP_SLTU = OPRN_WIDTH'(8'h0A);
    localparam logic [OPRN_WIDTH-1:0] OP_SRA  = OPRN_WIDTH'(8'h0B);
    localparam logic [OPRN_WIDTH-1:0] OP_DIVU = OPRN_WIDTH'(8'h0C);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t        state;
    logic [W:0]    acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opnd;
    logic [SW:0]   cnt;
    logic          is_mul;
    logic          res_dz;
    logic          res_err;

    logic [W-1:0]  c_y;
    logic [W-1:0]  c_hi;
    logic          c_dz;
    logic          c_err;
    logic [SW-1:0] sa;
    logic          big_shift;
    logic [W-1:0]  diff;
    logic [W-1:0]  sra_val;
    logic          iter_start;
    logic [W:0]    mul_sum;
    logic [W:0]    div_sh;
    logic [W:0]    div_sub;
    logic          div_ge;

    // Single-cycle results; DIVU only lands here when B == 0.
    always_comb begin
        sa         = B[SW-1:0];
        big_shift  = (B >= W'(W));
        diff       = A - B;
        sra_val    = $unsigned($signed(A) >>> sa);
        iter_start = (OPRN == OP_MUL) || ((OPRN == OP_DIVU) && (B != '0));
        c_y        = '0;
        c_hi       = '0;
        c_dz       = 1'b0;
        c_err      = 1'b0;
        case (OPRN)
            OP_ADD:  c_y = A + B;
            OP_SUB:  c_y = diff;
            OP_MUL:  c_y = '0;
            OP_SRL:  c_y = big_shift ? '0 : (A >> sa);
            OP_SLL:  c_y = big_shift ? '0 : (A << sa);
            OP_AND:  c_y = A & B;
            OP_OR:   c_y = A | B;
            OP_NOR:  c_y = ~(A | B);
            OP_SLT:  c_y = {{(W-1){1'b0}}, diff[W-1]};
            OP_SLTU: c_y = {{(W-1){1'b0}}, (A < B)};
            OP_SRA:  c_y = big_shift ? {W{A[W-1]}} : sra_val;
            OP_DIVU: begin
                c_y  = '1;
                c_hi = A;
                c_dz = 1'b1;
            end
            default: c_err = 1'b1;
        endcase
    end

    // One iteration step of each engine, selected in the FSM by is_mul.
    always_comb begin
        mul_sum = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh  = {acc_hi[W-1:0], acc_lo[W-1]};
        div_ge  = (div_sh >= {1'b0, opnd});
        div_sub = div_sh - {1'b0, opnd};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            Y       <= '0;
            HI      <= '0;
            ZERO    <= 1'b1;
            DZ      <= 1'b0;
            ERR     <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            cnt     <= '0;
            is_mul  <= 1'b0;
            res_dz  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        BUSY <= 1'b1;
                        if (iter_start) begin
                            is_mul  <= (OPRN == OP_MUL);
                            opnd    <= (OPRN == OP_MUL) ? A : B;
                            acc_lo  <= (OPRN == OP_MUL) ? B : A;
                            acc_hi  <= '0;
                            cnt     <= (SW+1)'(W);
                            res_dz  <= 1'b0;
                            res_err <= 1'b0;
                            state   <= S_ITER;
                        end else begin
                            acc_hi  <= {1'b0, c_hi};
                            acc_lo  <= c_y;
                            res_dz  <= c_dz;
                            res_err <= c_err;
                            state   <= S_FIN;
                        end
                    end
                end
                S_ITER: begin
                    if (is_mul) begin
                        acc_hi <= {1'b0, mul_sum[W:1]};
                        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                    end else begin
                        acc_hi <= {1'b0, (div_ge ? div_sub[W-1:0] : div_sh[W-1:0])};
                        acc_lo <= {acc_lo[W-2:0], div_ge};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == (SW+1)'(1)) state <= S_FIN;
                end
                S_FIN: begin
                    Y     <= acc_lo;
                    HI    <= acc_hi[W-1:0];
                    ZERO  <= (acc_lo == '0);
                    DZ    <= res_dz;
                    ERR   <= res_err;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at DATA_WIDTH 32 and 8 against a
// behavioural arithmetic model.
module tb_alu_seq;
    typedef struct {
        logic [31:0] y;
        logic [31:0] hi;
        logic        dz;
        logic        err;
        int          lat;
        int          start;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, start8;
    logic [5:0]  oprn;
    logic [31:0] a, b;
    logic        busy32, done32, zero32, dz32, err32;
    logic [31:0] y32, hi32;
    logic        busy8, done8, zero8, dz8, err8;
    logic [7:0]  y8, hi8;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q32[$];
    exp_t q8[$];

    alu_seq #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut32 (
        .CLK(clk), .RST(rst_n), .START(start32), .OPRN(oprn), .A(a), .B(b),
        .BUSY(busy32), .DONE(done32), .Y(y32), .HI(hi32), .ZERO(zero32), .DZ(dz32), .ERR(err32)
    );

    alu_seq #(.DATA_WIDTH(8), .OPRN_WIDTH(6)) dut8 (
        .CLK(clk), .RST(rst_n), .START(start8), .OPRN(oprn), .A(a[7:0]), .B(b[7:0]),
        .BUSY(busy8), .DONE(done8), .Y(y8), .HI(hi8), .ZERO(zero8), .DZ(dz8), .ERR(err8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [5:0] op,
                                   input logic [31:0] av, input logic [31:0] bv);
        longint unsigned m  = (64'd1 << w) - 64'd1;
        longint unsigned ua = {32'd0, av} & m;
        longint unsigned ub = {32'd0, bv} & m;
        longint unsigned uw = 64'(w);
        longint unsigned p;
        longint unsigned sgn;
        exp_t e;
        e.y = 32'd0; e.hi = 32'd0; e.dz = 1'b0; e.err = 1'b0; e.lat = 1; e.start = 0;
        sgn = (ua >> (w - 1)) & 64'd1;
        case (op)
            6'h01: e.y = 32'((ua + ub) & m);
            6'h02: e.y = 32'((ua - ub) & m);
            6'h03: begin
                p = ua * ub;
                e.y = 32'(p & m);
                e.hi = 32'((p >> w) & m);
                e.lat = w + 1;
            end
            6'h04: e.y = (ub >= uw) ? 32'd0 : 32'(ua >> ub);
            6'h05: e.y = (ub >= uw) ? 32'd0 : 32'((ua << ub) & m);
            6'h06: e.y = 32'(ua & ub);
            6'h07: e.y = 32'(ua | ub);
            6'h08: e.y = 32'(~(ua | ub) & m);
            6'h09: e.y = 32'((((ua - ub) & m) >> (w - 1)) & 64'd1);
            6'h0A: e.y = (ua < ub) ? 32'd1 : 32'd0;
            6'h0B: begin
                if (ub >= uw) e.y = (sgn != 0) ? 32'(m) : 32'd0;
                else e.y = 32'((ua >> ub) | ((sgn != 0) ? ((m << (uw - ub)) & m) : 64'd0));
            end
            6'h0C: begin
                if (ub == 0) begin
                    e.y = 32'(m); e.hi = 32'(ua); e.dz = 1'b1;
                end else begin
                    e.y = 32'(ua / ub); e.hi = 32'(ua % ub); e.lat = w + 1;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e, input logic [31:0] y, input logic [31:0] hi,
                           input logic zero, input logic dz, input logic err, input logic busy);
        check({tag, "_y"}, 64'(y), 64'(e.y));
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_zero"}, 64'(zero), 64'(e.y == 32'd0));
        check({tag, "_dz"}, 64'(dz), 64'(e.dz));
        check({tag, "_err"}, 64'(err), 64'(e.err));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_latency"}, 64'(cyc - e.start), 64'(e.lat));
    endtask

    // Monitors: every DONE must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done32) begin
            check("w32_done_expected", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) compare("w32", q32.pop_front(), y32, hi32, zero32, dz32, err32, busy32);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            check("w8_done_expected", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) compare("w8", q8.pop_front(), {24'd0, y8}, {24'd0, hi8}, zero8, dz8, err8, busy8);
        end
    end

    // Called at a negedge; leaves the bench just after the accepting edge.
    task automatic issue(input int w, input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        oprn = op; a = av; b = bv;
        if (w == 32) start32 = 1'b1; else start8 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; start8 = 1'b0;
        e = model(w, op, av, bv);
        e.start = cyc;
        if (w == 32) q32.push_back(e); else q8.push_back(e);
        oprn = 6'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input int w);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((w == 32) ? done32 : done8) break;
            check("busy_during_op", 64'((w == 32) ? busy32 : busy8), 64'd1);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL done_timeout: got no DONE expected DONE within 100 cycles (w=%0d)", w);
                break;
            end
        end
    endtask

    task automatic run(input int w, input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        issue(w, op, av, bv);
        wait_done(w);
    endtask

    task automatic check_reset(input int w);
        if (w == 32) begin
            check("rst32_busy", 64'(busy32), 64'd0);
            check("rst32_done", 64'(done32), 64'd0);
            check("rst32_y", 64'(y32), 64'd0);
            check("rst32_hi", 64'(hi32), 64'd0);
            check("rst32_zero", 64'(zero32), 64'd1);
            check("rst32_dz", 64'(dz32), 64'd0);
            check("rst32_err", 64'(err32), 64'd0);
        end else begin
            check("rst8_busy", 64'(busy8), 64'd0);
            check("rst8_done", 64'(done8), 64'd0);
            check("rst8_y", 64'(y8), 64'd0);
            check("rst8_hi", 64'(hi8), 64'd0);
            check("rst8_zero", 64'(zero8), 64'd1);
            check("rst8_dz", 64'(dz8), 64'd0);
            check("rst8_err", 64'(err8), 64'd0);
        end
    endtask

    task automatic random_ops(input int w, input int count);
        int r;
        logic [5:0] op;
        logic [31:0] bv;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 13);
            op = (r == 13) ? 6'($urandom_range(13, 63)) : 6'(r);
            bv = $urandom;
            if ($urandom_range(0, 2) == 0) bv = 32'($urandom_range(0, 2 * w));
            if (op == 6'h0C && $urandom_range(0, 4) == 0) bv = 32'd0;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run(w, op, $urandom, bv);
        end
    endtask

    initial begin
        rst_n = 1'b0; start32 = 1'b0; start8 = 1'b0; oprn = 6'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check_reset(32);
        check_reset(8);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset(32);
        check_reset(8);

        run(32, 6'h01, 32'hFFFF_FFFF, 32'd1);
        // MUL with a START burst in the middle that must be ignored.
        issue(32, 6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        oprn = 6'h01; a = 32'd1; b = 32'd1; start32 = 1'b1;
        repeat (3) @(negedge clk);
        start32 = 1'b0;
        wait_done(32);
        run(32, 6'h0C, 32'd100, 32'd7);
        run(32, 6'h0C, 32'd5, 32'd0);
        run(32, 6'h0B, 32'h8000_0000, 32'd4);
        run(32, 6'h0B, 32'h8000_0000, 32'd40);
        run(32, 6'h05, 32'h1234_5678, 32'd32);
        run(32, 6'h04, 32'h8765_4321, 32'd31);
        run(32, 6'h09, 32'hFFFF_FFFF, 32'd1);
        run(32, 6'h0A, 32'hFFFF_FFFF, 32'd1);
        run(32, 6'h3F, 32'h1111_1111, 32'h2222_2222);
        run(32, 6'h06, 32'hF0F0_F0F0, 32'hFFFF_0000);

        // Reset part-way through a MUL: no DONE may follow.
        issue(32, 6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset(32);
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_reset(32);
        run(32, 6'h02, 32'd5, 32'd3);

        run(8, 6'h03, 32'hFF, 32'hFF);
        run(8, 6'h0C, 32'd100, 32'd7);
        run(8, 6'h0C, 32'd5, 32'd0);
        run(8, 6'h0B, 32'h80, 32'd4);
        run(8, 6'h0B, 32'h80, 32'd9);
        run(8, 6'h05, 32'h5A, 32'd8);

        random_ops(32, 120);
        random_ops(8, 200);

        repeat (3) @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
